// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO feeding a UART transmitter: buffers producer bytes and launches one
// single-cycle flag per byte, only after the transmitter has shown idle twice in a row.
module uart_tx_fifo_feeder #(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              sys_clk_i,
    input  logic              rst_n_i,
    input  logic [7:0]        wr_data_i,
    input  logic              wr_en_i,
    input  logic              ovf_clr_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_data_flag_o,
    input  logic              tx_busy_i
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_ARM  = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                wr_accept_s;
    logic                pop_s;

    // Full is judged on the registered count, so a same-cycle pop cannot rescue a write.
    assign wr_accept_s = wr_en_i && !full_q;
    assign pop_s       = (state_q == ST_SEND);

    // Launch FSM: busy must read low in WAIT and again in ARM before SEND.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        case (state_q)
            ST_WAIT: begin
                if (!empty_q && !tx_busy_i) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ARM: begin
                if (!tx_busy_i) begin
                    state_d   = ST_SEND;
                    tx_data_d = mem_q[rd_ptr_q];
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // FIFO pointer, occupancy and sticky-overflow next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (wr_accept_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_accept_s, pop_s})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        if (wr_en_i && full_q) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        full_d  = (count_d == (ADDR_W + 1)'(DEPTH));
        empty_d = (count_d == (ADDR_W + 1)'(0));
    end

    // Control and status registers.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_WAIT;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Storage array; contents are meaningless outside the pointer window, so no reset.
    always_ff @(posedge sys_clk_i) begin
        if (wr_accept_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign tx_data_o      = tx_data_q;
    assign tx_data_flag_o = (state_q == ST_SEND);

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Randomized scoreboard bench for uart_tx_fifo_feeder with a simple busy model of the transmitter.
module tb_uart_tx_fifo_feeder;
    localparam int DEPTH = 16;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en   = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       noise   = 1'b0;
    logic       full, empty, overflow, flag, tx_busy;
    logic [4:0] count;
    logic [7:0] tx_data;

    int busy_cnt   = 0;
    int cyc        = 0;
    int checks     = 0;
    int failures   = 0;
    int flag_cyc   = -1;
    int flags_seen = 0;

    logic [7:0] exp_q [$];
    bit         m_ovf     = 1'b0;
    logic [7:0] last_sent = 8'h00;
    bit         busy_p1 = 1'b1, busy_p2 = 1'b1, flag_p1 = 1'b0;

    uart_tx_fifo_feeder #(.DEPTH(DEPTH)) dut (
        .sys_clk_i      (sys_clk),
        .rst_n_i        (rst_n),
        .wr_data_i      (wr_data),
        .wr_en_i        (wr_en),
        .ovf_clr_i      (ovf_clr),
        .full_o         (full),
        .empty_o        (empty),
        .count_o        (count),
        .overflow_o     (overflow),
        .tx_data_o      (tx_data),
        .tx_data_flag_o (flag),
        .tx_busy_i      (tx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Transmitter model: busy rises combinationally with the flag and stays up for a frame.
    assign tx_busy = flag | (busy_cnt != 0) | noise;

    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (flag) busy_cnt <= 3 + int'($urandom_range(0, 5));
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard / monitor: FIFO modelled as a queue, compared every cycle mid-period.
    initial begin
        int size0;
        forever begin
            @(negedge sys_clk);
            if (!rst_n) begin
                exp_q.delete();
                m_ovf = 1'b0;
                last_sent = 8'h00;
                chk("rst_flag", flag, 0);
                chk("rst_count", count, 0);
                chk("rst_empty", empty, 1);
                chk("rst_full", full, 0);
                chk("rst_ovf", overflow, 0);
                chk("rst_txdata", tx_data, 0);
                busy_p1 = 1'b1; busy_p2 = 1'b1; flag_p1 = 1'b0;
            end else begin
                size0 = exp_q.size();
                chk("count", count, size0);
                chk("full", full, (size0 == DEPTH) ? 1 : 0);
                chk("empty", empty, (size0 == 0) ? 1 : 0);
                chk("overflow", overflow, m_ovf);
                if (flag) begin
                    flags_seen++;
                    flag_cyc = cyc;
                    chk("flag_guard", {flag_p1, busy_p1, busy_p2}, 0);
                    if (size0 == 0) begin
                        chk("flag_unexpected", 1, 0);
                    end else begin
                        chk("tx_data", tx_data, exp_q[0]);
                        last_sent = exp_q.pop_front();
                    end
                end else begin
                    chk("tx_hold", tx_data, last_sent);
                end
                if (wr_en) begin
                    if (size0 < DEPTH) exp_q.push_back(wr_data);
                    else m_ovf = 1'b1;
                end
                if (!(wr_en && size0 == DEPTH) && ovf_clr) m_ovf = 1'b0;
                flag_p1 = flag; busy_p2 = busy_p1; busy_p1 = tx_busy;
            end
        end
    end

    task automatic drive(input bit we, input logic [7:0] d, input bit clr, input bit nz);
        @(posedge sys_clk);
        #1;
        wr_en = we; wr_data = d; ovf_clr = clr; noise = nz;
    endtask

    task automatic drain();
        int n = 0;
        drive(0, 8'h00, 0, 0);
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge sys_clk);
            n++;
        end
        repeat (2) @(posedge sys_clk);
        #1;
        chk("drain_done", exp_q.size(), 0);
        chk("drain_empty", empty, 1);
    endtask

    initial begin
        int wcyc;
        int flags0;
        repeat (3) @(posedge sys_clk);
        #1 rst_n = 1'b1;

        // Single byte latency
        repeat (5) drive(0, 8'h00, 0, 0);
        drive(1, 8'hA5, 0, 0);
        wcyc = cyc;
        drive(0, 8'h00, 0, 0);
        chk("count_after_write", count, 1);
        for (int i = 0; i < 10 && flag_cyc < wcyc; i++) @(negedge sys_clk);
        chk("latency", flag_cyc - wcyc, 3);
        chk("latency_data", tx_data, 8'hA5);

        // End-of-stop guard: one low busy cycle must not launch
        repeat (12) drive(0, 8'h00, 0, 1);
        drive(1, 8'h3C, 0, 1);
        repeat (3) drive(0, 8'h00, 0, 1);
        flags0 = flags_seen;
        drive(0, 8'h00, 0, 0);
        repeat (4) drive(0, 8'h00, 0, 1);
        chk("guard_no_flag", flags_seen, flags0);
        chk("guard_count", count, 1);
        drain();

        // Overflow
        for (int i = 1; i <= 16; i++) drive(1, 8'(i), 0, 1);
        drive(1, 8'hFF, 0, 1);
        drive(0, 8'h00, 0, 1);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 16);
        chk("ovf_full", full, 1);
        drive(1, 8'hEE, 1, 1);
        drive(0, 8'h00, 0, 1);
        chk("ovf_wins_clr", overflow, 1);
        drive(0, 8'h00, 1, 1);
        drive(0, 8'h00, 0, 1);
        chk("ovf_cleared", overflow, 0);
        drain();

        // Reset mid-burst
        for (int i = 0; i < 7; i++) drive(1, 8'(8'h40 + i), 0, 1);
        drive(0, 8'h00, 0, 1);
        chk("pre_rst_count", count, 7);
        @(posedge sys_clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_empty", empty, 1);
        chk("async_rst_flag", flag, 0);
        noise = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1 rst_n = 1'b1;

        // Random traffic: bursty phase, then slow phase
        for (int i = 0; i < 4000; i++)
            drive(($urandom % 3) == 0, 8'($urandom), ($urandom % 16) == 0, ($urandom % 8) == 0);
        for (int i = 0; i < 1500; i++)
            drive(($urandom % 8) == 0, 8'($urandom), ($urandom % 16) == 0, ($urandom % 8) == 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
